regfile: RTL and testbench

//  - Integer register file (x0..x31) for the RV32I core. It is the responder end of the decode-stage read interface.
//  - Decode drives rs1/rs2 addresses and consumes the returned data in the same cycle.
//  - Writeback drives rd/enable/data.
//  - After reset, a sequential init engine clears the array so it maps onto RAM-style storage.
//  - A registered debug read port exposes registers to the SoC debug/peripheral bus.

---
 rtl/regfile.sv | 117 +++++++++++
 tb/tb_regfile.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// RV32I integer register file: two combinational read ports, one write port,
// a registered debug read port, and a post-reset engine that clears the storage.
module regfile #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int BYPASS_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr_in,
  input  logic [ADDR_W-1:0] rs2_addr_in,
  output logic [DATA_W-1:0] rs1_data_out,
  output logic [DATA_W-1:0] rs2_data_out,
  input  logic              reg_wr_en_in,
  input  logic [ADDR_W-1:0] reg_wr_addr_in,
  input  logic [DATA_W-1:0] reg_wr_data_in,
  input  logic [ADDR_W-1:0] dbg_addr_in,
  output logic [DATA_W-1:0] dbg_data_out,
  output logic              init_busy_out
);

  typedef enum logic {INIT, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_idx, init_idx_nxt;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              ready;
  logic [DATA_W-1:0] rs1_stored, rs2_stored, dbg_stored;

  // x0 and addresses past the implemented registers never hold data.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (addr != '0) && (int'(addr) < NUM_REGS);
  endfunction

  function automatic logic [DATA_W-1:0] resolve(
    input logic              rdy,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
  );
    if (!rdy || !in_range(addr))
      return '0;
    if ((BYPASS_EN != 0) && wr_en && (wr_addr == addr))
      return wr_data;
    return stored;
  endfunction

  assign ready = (state == READY);

  always_comb begin
    state_nxt    = state;
    init_idx_nxt = init_idx;
    case (state)
      INIT: begin
        if (init_idx == LAST_IDX)
          state_nxt = READY;
        else
          init_idx_nxt = init_idx + 1'b1;
      end
      READY: begin
        state_nxt = READY;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT;
      init_idx      <= ADDR_W'(1);
      init_busy_out <= 1'b1;
    end else begin
      state         <= state_nxt;
      init_idx      <= init_idx_nxt;
      init_busy_out <= (state_nxt == INIT);
    end
  end

  // Storage has no reset; the init engine clears it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)
        regs[init_idx] <= '0;
      else if (reg_wr_en_in && in_range(reg_wr_addr_in))
        regs[reg_wr_addr_in] <= reg_wr_data_in;
    end
  end

  always_comb begin
    rs1_stored = in_range(rs1_addr_in) ? regs[rs1_addr_in] : '0;
    rs2_stored = in_range(rs2_addr_in) ? regs[rs2_addr_in] : '0;
    dbg_stored = in_range(dbg_addr_in) ? regs[dbg_addr_in] : '0;
  end

  assign rs1_data_out = resolve(ready, rs1_addr_in, rs1_stored,
                                reg_wr_en_in, reg_wr_addr_in, reg_wr_data_in);
  assign rs2_data_out = resolve(ready, rs2_addr_in, rs2_stored,
                                reg_wr_en_in, reg_wr_addr_in, reg_wr_data_in);

  // Debug read stage: one-cycle registered view of the same read path.
  always_ff @(posedge clk) begin
    if (rst)
      dbg_data_out <= '0;
    else
      dbg_data_out <= resolve(ready, dbg_addr_in, dbg_stored,
                              reg_wr_en_in, reg_wr_addr_in, reg_wr_data_in);
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// compared against an array-based model of the architectural registers.
module tb_regfile;
  localparam int NUM_REGS  = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int BYPASS_EN = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] rs1_addr_in = '0;
  logic [ADDR_W-1:0] rs2_addr_in = '0;
  logic [DATA_W-1:0] rs1_data_out;
  logic [DATA_W-1:0] rs2_data_out;
  logic              reg_wr_en_in = 1'b0;
  logic [ADDR_W-1:0] reg_wr_addr_in = '0;
  logic [DATA_W-1:0] reg_wr_data_in = '0;
  logic [ADDR_W-1:0] dbg_addr_in = '0;
  logic [DATA_W-1:0] dbg_data_out;
  logic              init_busy_out;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] model [NUM_REGS];

  always #5 clk = ~clk;

  regfile #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYPASS_EN(BYPASS_EN)
  ) dut (
    .clk(clk), .rst(rst),
    .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
    .reg_wr_en_in(reg_wr_en_in), .reg_wr_addr_in(reg_wr_addr_in),
    .reg_wr_data_in(reg_wr_data_in),
    .dbg_addr_in(dbg_addr_in), .dbg_data_out(dbg_data_out),
    .init_busy_out(init_busy_out)
  );

  // Architectural read value for a READY-state read, given the write port inputs.
  function automatic logic [DATA_W-1:0] expect_read(input int addr, input bit wr_en,
                                                    input int wr_addr,
                                                    input logic [DATA_W-1:0] wr_data);
    if (addr == 0 || addr >= NUM_REGS) return '0;
    if (BYPASS_EN != 0 && wr_en && wr_addr == addr) return wr_data;
    return model[addr];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_wr_en_in   = 1'b0;
    reg_wr_addr_in = '0;
    reg_wr_data_in = '0;
  endtask

  task automatic model_write(input bit wr_en, input int addr, input logic [DATA_W-1:0] data);
    if (wr_en && addr != 0 && addr < NUM_REGS) model[addr] = data;
  endtask

  task automatic do_reset(input int n);
    idle_inputs();
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
    tests++;
    if (init_busy_out !== 1'b1) begin
      fails++;
      $display("FAIL reset_busy: got %b expected 1", init_busy_out);
    end
    tests++;
    if (dbg_data_out !== '0) begin
      fails++;
      $display("FAIL reset_dbg: got %h expected 0", dbg_data_out);
    end
  endtask

  // Steps through init while busy; optionally tries a write of x3 before init edge wr_edge.
  task automatic run_init(input int wr_edge, output int edges);
    edges = 0;
    while (init_busy_out === 1'b1 && edges < 64) begin
      rs1_addr_in = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      rs2_addr_in = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      if (edges + 1 == wr_edge) begin
        reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd3; reg_wr_data_in = 32'hAA;
        rs1_addr_in = 5'd3;
      end else begin
        idle_inputs();
      end
      #1;
      tests++;
      if (rs1_data_out !== '0 || rs2_data_out !== '0) begin
        fails++;
        $display("FAIL init_read_zero: got %h/%h expected 0", rs1_data_out, rs2_data_out);
      end
      step();
      edges++;
      tests++;
      if (dbg_data_out !== '0) begin
        fails++;
        $display("FAIL init_dbg_zero: got %h expected 0", dbg_data_out);
      end
    end
    idle_inputs();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endtask

  task automatic check_all_zero(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < NUM_REGS; a++) begin
      rs1_addr_in = ADDR_W'(a);
      rs2_addr_in = ADDR_W'(NUM_REGS - 1 - a);
      #1;
      if (rs1_data_out !== '0 || rs2_data_out !== '0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: got %0d nonzero reads expected 0", tag, bad);
    end
  endtask

  task automatic test_reset();
    int edges;
    do_reset(2);
    run_init(2, edges);
    tests++;
    if (edges != NUM_REGS - 1) begin
      fails++;
      $display("FAIL init_length: got %0d edges expected %0d", edges, NUM_REGS - 1);
    end
    step();
    tests++;
    if (init_busy_out !== 1'b0) begin
      fails++;
      $display("FAIL busy_stays_low: got %b expected 0", init_busy_out);
    end
    check_all_zero("init_clear");
    rs1_addr_in = 5'd3; #1;
    tests++;
    if (rs1_data_out !== '0) begin
      fails++;
      $display("FAIL init_protect_x3: got %h expected 0", rs1_data_out);
    end
  endtask

  task automatic test_write_read();
    reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd5; reg_wr_data_in = 32'hDEADBEEF;
    step();
    model_write(1'b1, 5, 32'hDEADBEEF);
    idle_inputs();
    rs1_addr_in = 5'd5; rs2_addr_in = 5'd5; #1;
    tests++;
    if (rs1_data_out !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL wr_rd_rs1: got %h expected deadbeef", rs1_data_out);
    end
    tests++;
    if (rs2_data_out !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL wr_rd_rs2: got %h expected deadbeef", rs2_data_out);
    end
  endtask

  task automatic test_x0();
    reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd0; reg_wr_data_in = 32'h12345678;
    rs1_addr_in = 5'd0; rs2_addr_in = 5'd0; dbg_addr_in = 5'd0; #1;
    tests++;
    if (rs1_data_out !== '0 || rs2_data_out !== '0) begin
      fails++;
      $display("FAIL x0_bypass: got %h/%h expected 0", rs1_data_out, rs2_data_out);
    end
    step();
    idle_inputs(); #1;
    tests++;
    if (rs1_data_out !== '0) begin
      fails++;
      $display("FAIL x0_read: got %h expected 0", rs1_data_out);
    end
    tests++;
    if (dbg_data_out !== '0) begin
      fails++;
      $display("FAIL x0_dbg: got %h expected 0", dbg_data_out);
    end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] exp;
    reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd7; reg_wr_data_in = 32'h11;
    step();
    model_write(1'b1, 7, 32'h11);
    reg_wr_data_in = 32'h22;
    rs1_addr_in = 5'd7; rs2_addr_in = 5'd7; dbg_addr_in = 5'd7; #1;
    exp = (BYPASS_EN != 0) ? 32'h22 : 32'h11;
    tests++;
    if (rs1_data_out !== exp || rs2_data_out !== exp) begin
      fails++;
      $display("FAIL bypass_both: got %h/%h expected %h", rs1_data_out, rs2_data_out, exp);
    end
    step();
    model_write(1'b1, 7, 32'h22);
    idle_inputs();
    tests++;
    if (dbg_data_out !== exp) begin
      fails++;
      $display("FAIL bypass_dbg: got %h expected %h", dbg_data_out, exp);
    end
    #1;
    tests++;
    if (rs1_data_out !== 32'h22) begin
      fails++;
      $display("FAIL bypass_commit: got %h expected 22", rs1_data_out);
    end
  endtask

  task automatic test_random();
    int bad_rs, bad_dbg;
    logic [DATA_W-1:0] e1, e2, ed;
    bit we; int wa; logic [DATA_W-1:0] wd;
    bad_rs = 0; bad_dbg = 0;
    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(0, 2) != 0);
      wa = $urandom_range(0, NUM_REGS - 1);
      wd = $urandom;
      reg_wr_en_in = we; reg_wr_addr_in = ADDR_W'(wa); reg_wr_data_in = wd;
      rs1_addr_in = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      rs2_addr_in = ($urandom_range(0, 3) == 0) ? ADDR_W'(wa)
                                                : ADDR_W'($urandom_range(0, NUM_REGS - 1));
      dbg_addr_in = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      #1;
      e1 = expect_read(int'(rs1_addr_in), we, wa, wd);
      e2 = expect_read(int'(rs2_addr_in), we, wa, wd);
      ed = expect_read(int'(dbg_addr_in), we, wa, wd);
      if (rs1_data_out !== e1 || rs2_data_out !== e2) begin
        bad_rs++;
        if (bad_rs < 4)
          $display("FAIL rand_rs: got %h/%h expected %h/%h", rs1_data_out, rs2_data_out, e1, e2);
      end
      step();
      model_write(we, wa, wd);
      if (dbg_data_out !== ed) begin
        bad_dbg++;
        if (bad_dbg < 4)
          $display("FAIL rand_dbg: got %h expected %h", dbg_data_out, ed);
      end
    end
    idle_inputs();
    tests++;
    if (bad_rs != 0) fails++;
    tests++;
    if (bad_dbg != 0) fails++;
  endtask

  task automatic test_reset_mid();
    int edges;
    reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd9; reg_wr_data_in = 32'h55;
    step();
    idle_inputs();
    rs1_addr_in = 5'd9; #1;
    tests++;
    if (rs1_data_out !== 32'h55) begin
      fails++;
      $display("FAIL mid_pre_x9: got %h expected 55", rs1_data_out);
    end
    do_reset(1);
    repeat (10) step();
    tests++;
    if (init_busy_out !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy_10: got %b expected 1", init_busy_out);
    end
    do_reset(1);
    run_init(0, edges);
    tests++;
    if (edges != NUM_REGS - 1) begin
      fails++;
      $display("FAIL mid_init_length: got %0d edges expected %0d", edges, NUM_REGS - 1);
    end
    rs1_addr_in = 5'd9; dbg_addr_in = 5'd9; #1;
    tests++;
    if (rs1_data_out !== '0) begin
      fails++;
      $display("FAIL mid_x9_rs: got %h expected 0", rs1_data_out);
    end
    step();
    tests++;
    if (dbg_data_out !== '0) begin
      fails++;
      $display("FAIL mid_x9_dbg: got %h expected 0", dbg_data_out);
    end
    check_all_zero("mid_clear");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
